// File: rtl/nn_result_reader.sv
// nn_result_reader: drains NUM_CLASSES signed scores from the score memory, streams them out and reports the argmax.
// Ports: CLOCK/RESET (sync, active-high); start pulse in, busy out; RA1/RD1 async memory read port;
// m_valid/m_ready/m_data/m_index/m_last score stream; done pulse; class_valid/class_idx/class_score result.
// Optional macro NN_RESULT_CLEAR_EN adds WA2/WD2/WE2 to zero each score as it is handed off.
module nn_result_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] RA1,
  input  logic [DATA_W-1:0] RD1,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              done,
  output logic              class_valid,
  output logic [ADDR_W-1:0] class_idx,
  output logic [DATA_W-1:0] class_score
`ifdef NN_RESULT_CLEAR_EN
  ,
  output logic [ADDR_W-1:0] WA2,
  output logic [DATA_W-1:0] WD2,
  output logic              WE2
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLASSES - 1);
  logic [1:0] state;
  logic [ADDR_W-1:0] idx, best_i;
  logic [DATA_W-1:0] best;
  assign RA1 = idx;
  assign m_valid = state == SEND;
  assign done = state == FIN;
`ifdef NN_RESULT_CLEAR_EN
  assign WE2 = m_valid && m_ready;
  assign WA2 = idx;
  assign WD2 = '0;
`endif
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      m_data <= '0;
      m_index <= '0;
      m_last <= 1'b0;
      class_valid <= 1'b0;
      class_idx <= '0;
      class_score <= '0;
      best <= '0;
      best_i <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          busy <= 1'b1;
          class_valid <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          m_data <= RD1;
          m_index <= idx;
          m_last <= idx == LAST;
          // index 0 seeds the running max so all-negative inputs still resolve
          if (idx == '0 || $signed(RD1) > $signed(best)) begin
            best <= RD1;
            best_i <= idx;
          end
          state <= SEND;
        end
        SEND: if (m_ready) begin
          if (m_last) state <= FIN;
          else begin
            idx <= idx + 1'b1;
            state <= LOAD;
          end
        end
        default: begin
          class_valid <= 1'b1;
          class_idx <= best_i;
          class_score <= best;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
